// File: rtl/uart_rx_controller.sv
// uart_rx_controller: receives UART bytes from the RX pin, queues them in a small byte
// FIFO, and writes them into the current fill buffer of the triple-buffered SRAM.
// A one-cycle swap pulse is issued after every BUF_LEN written bytes.
// The default frame is 8N1. Define UART_RX_PARITY_EN to select 8E1 frames and check
// even parity; a byte that fails the parity check is discarded.
module uart_rx_controller #(
  parameter int unsigned clk_per_bit = 87,
  parameter int unsigned BUF_LEN     = 1001,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx_in,
  input  logic        flow_control,
  output logic [15:0] sram_data,
  output logic [15:0] sram_addr,
  output logic        sram_start,
  input  logic        sram_ready,
  output logic        sram_rw,
  output logic        swap,
  output logic        overrun,
  output logic        framing_err,
  output logic        parity_err
);

  localparam int unsigned CNT_W = $clog2(clk_per_bit);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(clk_per_bit / 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(clk_per_bit - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   PTR_FULL  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [15:0]      ADDR_LAST = 16'(BUF_LEN - 1);

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
`ifdef UART_RX_PARITY_EN
    R_PARITY,
`endif
    R_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_START,
    W_WAIT,
    W_SWAP
  } wr_state_t;

  // Synchroniser
  logic r_sync1;
  logic r_sync2;
  logic w_rx;

  // Deserialiser
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_overrun;
  logic             r_framing_err;
`ifdef UART_RX_PARITY_EN
  logic             r_par_bad;
  logic             r_parity_err;
`endif

  // Byte FIFO; pointers carry one extra bit so full and empty are distinguishable
  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [PTR_W:0]   w_count;
  logic             w_full;
  logic             w_empty;

  // SRAM writer
  wr_state_t        r_wr_state;
  logic [15:0]      r_sram_data;
  logic [15:0]      r_sram_addr;
  logic             r_sram_start;
  logic             r_swap;

  logic             w_stop_sample;
  logic             w_frame_ok;
  logic             w_push;
  logic             w_launch;

  assign w_rx    = r_sync2;
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == PTR_FULL);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign w_stop_sample = (r_rx_state == R_STOP) && (r_cnt == CNT_LAST);
`ifdef UART_RX_PARITY_EN
  assign w_frame_ok = w_rx && !r_par_bad;
`else
  assign w_frame_ok = w_rx;
`endif
  assign w_push   = w_stop_sample && w_frame_ok && !w_full;
  assign w_launch = (r_wr_state == W_IDLE) && !w_empty && sram_ready && !flow_control;

  // Two-flop synchroniser for the asynchronous RX pin; resets to the idle (high) level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx_in;
      r_sync2 <= r_sync1;
    end
  end

  // Deserialiser FSM: start-bit qualification at mid-bit, then one sample per bit period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state    <= R_IDLE;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_wr_ptr      <= '0;
      r_overrun     <= 1'b0;
      r_framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad     <= 1'b0;
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_overrun     <= 1'b0;
      r_framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      case (r_rx_state)
        R_IDLE: begin
          if (!w_rx) begin
            r_rx_state <= R_START;
            r_cnt      <= '0;
          end
        end
        R_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            if (!w_rx) begin
              r_rx_state <= R_DATA;
              r_bit_idx  <= '0;
            end else begin
              r_rx_state <= R_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        R_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_rx_state <= R_PARITY;
`else
              r_rx_state <= R_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        R_PARITY: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt      <= '0;
            r_par_bad  <= w_rx ^ (^r_shift);
            r_rx_state <= R_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
`endif
        R_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt      <= '0;
            r_rx_state <= R_IDLE;
            if (!w_rx) begin
              r_framing_err <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            if (r_par_bad) begin
              r_parity_err <= 1'b1;
            end
`endif
            if (w_frame_ok && w_full) begin
              r_overrun <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_rx_state <= R_IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers gate every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[PTR_W-1:0]] <= r_shift;
    end
  end

  // SRAM writer FSM: launch one write per byte, advance address on completion, wrap with swap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_state   <= W_IDLE;
      r_rd_ptr     <= '0;
      r_sram_data  <= '0;
      r_sram_addr  <= '0;
      r_sram_start <= 1'b0;
      r_swap       <= 1'b0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (w_launch) begin
            r_sram_data  <= {8'h00, r_fifo[r_rd_ptr[PTR_W-1:0]]};
            r_sram_start <= 1'b1;
            r_rd_ptr     <= r_rd_ptr + PTR_ONE;
            r_wr_state   <= W_START;
          end
        end
        W_START: begin
          r_sram_start <= 1'b0;
          r_wr_state   <= W_WAIT;
        end
        W_WAIT: begin
          if (sram_ready) begin
            if (r_sram_addr == ADDR_LAST) begin
              r_sram_addr <= '0;
              r_swap      <= 1'b1;
              r_wr_state  <= W_SWAP;
            end else begin
              r_sram_addr <= r_sram_addr + 16'd1;
              r_wr_state  <= W_IDLE;
            end
          end
        end
        W_SWAP: begin
          r_swap     <= 1'b0;
          r_wr_state <= W_IDLE;
        end
        default: begin
          r_wr_state <= W_IDLE;
        end
      endcase
    end
  end

  assign sram_data   = r_sram_data;
  assign sram_addr   = r_sram_addr;
  assign sram_start  = r_sram_start;
  assign sram_rw     = 1'b0;
  assign swap        = r_swap;
  assign overrun     = r_overrun;
  assign framing_err = r_framing_err;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_parity_err;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: serial frames in, SRAM write stream checked against a
// queue-based model of the expected byte stream, buffer addresses and pulse counts.
module tb_uart_rx_controller;

  localparam int unsigned CPB = 8;
  localparam int unsigned BL  = 5;
  localparam int unsigned FD  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        uart_rx_in;
  logic        flow_control;
  logic [15:0] sram_data;
  logic [15:0] sram_addr;
  logic        sram_start;
  logic        sram_ready;
  logic        sram_rw;
  logic        swap;
  logic        overrun;
  logic        framing_err;
  logic        parity_err;

  uart_rx_controller #(
    .clk_per_bit(CPB),
    .BUF_LEN    (BL),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .uart_rx_in  (uart_rx_in),
    .flow_control(flow_control),
    .sram_data   (sram_data),
    .sram_addr   (sram_addr),
    .sram_start  (sram_start),
    .sram_ready  (sram_ready),
    .sram_rw     (sram_rw),
    .swap        (swap),
    .overrun     (overrun),
    .framing_err (framing_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] exp_q[$];
  logic [7:0] held_q[$];
  bit         hold = 1'b0;
  int         exp_addr = 0;
  int         last_addr = -1;
  int         exp_fe = 0, exp_ovr = 0, exp_swap = 0;
  int         fe_seen = 0, ovr_seen = 0, pe_seen = 0, swap_seen = 0;
  int         rst_cnt = 0;
  int unsigned lat_min = 0, lat_max = 0;
  logic [7:0] mon_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame outcome from the protocol rules: bad stop drops, full queue overruns
  function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) exp_fe++;
    else if (hold) begin
      if (held_q.size() < FD) held_q.push_back(b);
      else exp_ovr++;
    end else exp_q.push_back(b);
  endfunction

  task automatic set_hold();
    flow_control = 1'b1;
    hold = 1'b1;
  endtask

  task automatic release_hold();
    flow_control = 1'b0;
    hold = 1'b0;
    while (held_q.size() != 0) exp_q.push_back(held_q.pop_front());
  endtask

  task automatic drive_bit(input logic v);
    @(posedge clk); #1;
    uart_rx_in = v;
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    model_frame(b, stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_ok);
    @(posedge clk); #1;
    uart_rx_in = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !sram_ready) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    check_eq({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic phase_check(input string tag);
    check_eq({tag, "_framing"}, fe_seen, exp_fe);
    check_eq({tag, "_overrun"}, ovr_seen, exp_ovr);
    check_eq({tag, "_swaps"}, swap_seen, exp_swap);
    check_eq({tag, "_parity"}, pe_seen, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_data"}, sram_data, 0);
    check_eq({tag, "_addr"}, sram_addr, 0);
    check_eq({tag, "_pulses"}, {sram_start, swap, overrun, framing_err, parity_err, sram_rw}, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    reset = 1'b1;
    rst_cnt++;
    uart_rx_in = 1'b1;
    flow_control = 1'b0;
    hold = 1'b0;
    exp_q.delete();
    held_q.delete();
    exp_addr = 0;
    repeat (2) @(posedge clk); #1;
    check_idle_outputs(tag);
    reset = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // SRAM model: each accepted write keeps ready low for a random latency
  initial begin
    int unsigned lat;
    int epoch;
    logic [15:0] held;
    sram_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (sram_start && !reset) begin
        lat   = $urandom_range(lat_max, lat_min);
        held  = sram_data;
        epoch = rst_cnt;
        if (lat > 0) begin
          sram_ready = 1'b0;
          repeat (lat) @(posedge clk);
          #1;
          if (epoch == rst_cnt && !reset) check_eq("data_hold", sram_data, held);
          sram_ready = 1'b1;
        end
      end
    end
  end

  // Write/pulse monitor sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (framing_err) fe_seen++;
      if (overrun) ovr_seen++;
      if (parity_err) pe_seen++;
      if (swap) begin
        swap_seen++;
        check_eq("swap_prev_addr", last_addr, BL - 1);
        check_eq("swap_addr_wrap", sram_addr, 0);
      end
      if (sram_start) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write", {16'h0, sram_data}, 32'hFFFF_FFFF);
        end else begin
          mon_b = exp_q.pop_front();
          check_eq("wr_data", sram_data, {8'h00, mon_b});
          check_eq("wr_addr", sram_addr, exp_addr);
          last_addr = exp_addr;
          if (exp_addr == BL - 1) exp_swap++;
          exp_addr = (exp_addr + 1) % BL;
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    uart_rx_in = 1'b1;
    flow_control = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // single byte
    lat_min = 1; lat_max = 3;
    send_frame(8'hA5, 1'b1);
    wait_drain("a5");
    check_eq("a5_addr_next", sram_addr, 1);
    do_reset("rst_a");

    // full buffer plus wrap
    for (int i = 1; i <= 6; i++) send_frame(8'(i), 1'b1);
    wait_drain("buf");
    check_eq("buf_addr_next", sram_addr, 1);
    phase_check("buf");

    // flow control holds the writer, FIFO overflows
    set_hold();
    for (int i = 1; i <= 6; i++) send_frame(8'(i), 1'b1);
    repeat (20) @(posedge clk);
    phase_check("flow_hold");
    release_hold();
    wait_drain("flow");
    phase_check("flow");

    // bad stop bit then a good frame
    send_frame(8'h3C, 1'b0);
    send_frame(8'h3D, 1'b1);
    wait_drain("frm");
    phase_check("frm");

    // short low glitch on the line
    @(posedge clk); #1;
    uart_rx_in = 1'b0;
    repeat (2) @(posedge clk); #1;
    uart_rx_in = 1'b1;
    repeat (12 * CPB) @(posedge clk);
    phase_check("glitch");

    // randomized frames, latencies and flow control
    lat_min = 0; lat_max = 4;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(7, 0) == 0) begin
        if (hold) release_hold();
        else set_hold();
      end
      send_frame(8'($urandom_range(255, 0)), $urandom_range(5, 0) != 0);
    end
    release_hold();
    wait_drain("rand");
    phase_check("rand");

    // reset in the middle of a frame
    @(posedge clk); #1;
    uart_rx_in = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    do_reset("rst_byte");

    // reset while the writer waits on a slow SRAM
    lat_min = 30; lat_max = 30;
    send_frame(8'h5A, 1'b1);
    repeat (3) @(posedge clk);
    do_reset("rst_wait");
    repeat (40) @(posedge clk);
    lat_min = 1; lat_max = 3;
    send_frame(8'h77, 1'b1);
    wait_drain("post_rst");
    check_eq("post_rst_addr", sram_addr, 1);
    phase_check("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
